student_ss_analog_seq: RTL and testbench

Break-before-make scan sequencer for the analog student area pad switches. It steps through a masked set of analog channels. For each channel it opens all switches for a dead time, closes that channel's switch, and waits a settle time. It then hands a conversion request to the external converter and waits for its acknowledge. The block sits between the student-area control registers and the analog IO switch enables, so only one analog channel is ever connected to the core at a time.

---
 rtl/student_ss_analog_seq.sv | 137 +++++++++++++
 tb/tb_student_ss_analog_seq.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/student_ss_analog_seq.sv
// Break-before-make scan sequencer: walks the masked analog channels, opening every
// switch for a dead time before closing each one and handing it to the converter.
module student_ss_analog_seq #(
  parameter  int NUM_IO = 2,
  parameter  int CNT_W  = 8,
  localparam int CW     = (NUM_IO > 1) ? $clog2(NUM_IO) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_i,
  input  logic              stop_i,
  input  logic              continuous_i,
  input  logic [NUM_IO-1:0] chan_mask_i,
  input  logic [CNT_W-1:0]  dead_cycles_i,
  input  logic [CNT_W-1:0]  settle_cycles_i,
  input  logic              conv_ack_i,
  output logic [NUM_IO-1:0] sw_en_o,
  output logic              conv_req_o,
  output logic [CW-1:0]     chan_o,
  output logic              busy_o,
  output logic              done_o
);

  typedef enum logic [1:0] {IDLE, DEAD, SETTLE, CONV} state_t;

  state_t            state, state_n;
  logic [NUM_IO-1:0] mask_q, mask_n;
  logic [CNT_W-1:0]  dead_q, dead_n, settle_q, settle_n, cnt, cnt_n;
  logic [CW-1:0]     chan_n;
  logic              done_n;
  logic              above_found;
  logic [CW-1:0]     above_idx;
  logic [NUM_IO-1:0] onehot_n;

  function automatic logic [CW-1:0] lowest_set(input logic [NUM_IO-1:0] m);
    lowest_set = '0;
    for (int i = NUM_IO - 1; i >= 0; i--)
      if (m[i]) lowest_set = CW'(i);
  endfunction

  // Lowest snapshot channel strictly above the current one; descending scan keeps the lowest hit.
  always_comb begin
    above_found = 1'b0;
    above_idx   = '0;
    for (int i = NUM_IO - 1; i >= 0; i--) begin
      if (mask_q[i] && (i > int'(chan_o))) begin
        above_found = 1'b1;
        above_idx   = CW'(i);
      end
    end
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    chan_n   = chan_o;
    mask_n   = mask_q;
    dead_n   = dead_q;
    settle_n = settle_q;
    done_n   = 1'b0;
    if (stop_i) begin
      state_n = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (start_i && (chan_mask_i != '0)) begin
            state_n  = DEAD;
            mask_n   = chan_mask_i;
            dead_n   = dead_cycles_i;
            settle_n = settle_cycles_i;
            chan_n   = lowest_set(chan_mask_i);
            cnt_n    = dead_cycles_i;
          end
        end
        DEAD: begin
          if (cnt == '0) begin
            state_n = SETTLE;
            cnt_n   = settle_q;
          end else begin
            cnt_n = cnt - CNT_W'(1);
          end
        end
        SETTLE: begin
          if (cnt == '0) state_n = CONV;
          else           cnt_n   = cnt - CNT_W'(1);
        end
        CONV: begin
          if (conv_ack_i) begin
            if (above_found) begin
              state_n = DEAD;
              chan_n  = above_idx;
              cnt_n   = dead_q;
            end else if (continuous_i) begin
              state_n = DEAD;
              chan_n  = lowest_set(mask_q);
              cnt_n   = dead_q;
            end else begin
              state_n = IDLE;
              done_n  = 1'b1;
            end
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  assign onehot_n = NUM_IO'(1) << chan_n;

  // Outputs are decoded from the next state so the switch opens on the very edge that leaves CONV.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      mask_q     <= '0;
      dead_q     <= '0;
      settle_q   <= '0;
      chan_o     <= '0;
      sw_en_o    <= '0;
      conv_req_o <= 1'b0;
      done_o     <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      mask_q     <= mask_n;
      dead_q     <= dead_n;
      settle_q   <= settle_n;
      chan_o     <= chan_n;
      sw_en_o    <= ((state_n == SETTLE) || (state_n == CONV)) ? onehot_n : '0;
      conv_req_o <= (state_n == CONV);
      done_o     <= done_n;
    end
  end

  assign busy_o = (state != IDLE);

endmodule

// File: tb/tb_student_ss_analog_seq.sv
// Self-checking bench for the analog scan sequencer: vector table, scenario sequences
// and randomized scans compared against a per-cycle trace built from the timing rules.
module tb_student_ss_analog_seq;

  localparam int NUM_IO = 4;
  localparam int CNT_W  = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start_i = 1'b0, stop_i = 1'b0, continuous_i = 1'b0, conv_ack_i = 1'b0;
  logic [3:0] chan_mask_i = '0;
  logic [7:0] dead_cycles_i = '0, settle_cycles_i = '0;
  logic [3:0] sw_en_o;
  logic       conv_req_o, busy_o, done_o;
  logic [1:0] chan_o;

  int checks = 0;
  int errors = 0;

  student_ss_analog_seq #(.NUM_IO(NUM_IO), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .start_i(start_i), .stop_i(stop_i),
    .continuous_i(continuous_i), .chan_mask_i(chan_mask_i),
    .dead_cycles_i(dead_cycles_i), .settle_cycles_i(settle_cycles_i),
    .conv_ack_i(conv_ack_i), .sw_en_o(sw_en_o), .conv_req_o(conv_req_o),
    .chan_o(chan_o), .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       start, stop, cont, ack;
    logic [3:0] mask;
    logic [7:0] dead, settle;
    logic [3:0] sw;
    logic       req, busy, done;
    logic [1:0] chan;
  } vec_t;

  typedef struct {
    logic       ack;
    logic [3:0] sw;
    logic       req, busy, done;
    logic [1:0] chan;
  } cyc_t;

  vec_t vecs[13];
  cyc_t trace[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic start, input logic stop, input logic cont,
                                input logic ack, input logic [3:0] mask,
                                input logic [7:0] dead, input logic [7:0] settle);
    start_i = start; stop_i = stop; continuous_i = cont; conv_ack_i = ack;
    chan_mask_i = mask; dead_cycles_i = dead; settle_cycles_i = settle;
  endtask

  task automatic check_output(input string tag, input logic [3:0] sw, input logic req,
                              input logic busy, input logic done, input logic [1:0] chan);
    check({tag, "_sw"},   32'(sw_en_o),    32'(sw));
    check({tag, "_req"},  32'(conv_req_o), 32'(req));
    check({tag, "_busy"}, 32'(busy_o),     32'(busy));
    check({tag, "_done"}, 32'(done_o),     32'(done));
    check({tag, "_chan"}, 32'(chan_o),     32'(chan));
  endtask

  // Safety invariants hold on every cycle regardless of scenario.
  always @(negedge clk) begin
    check("onehot0", 32'($onehot0(sw_en_o)), 32'd1);
    check("req_needs_sw", 32'(!conv_req_o || (sw_en_o != '0)), 32'd1);
  end

  // Expected cycle stream of a non-continuous scan: per channel dead+1 open cycles,
  // settle+1 closed cycles, delay+1 request cycles, then one done cycle.
  task automatic run_trace(input string tag, input logic [3:0] mask, input logic [7:0] dead,
                           input logic [7:0] settle, input int max_delay, input bit noisy);
    cyc_t       e;
    bit         first;
    int         delay;
    logic [1:0] last_ch;
    trace.delete();
    first = 1'b1;
    last_ch = '0;
    for (int c = 0; c < 4; c++) begin
      if (mask[c]) begin
        delay = (max_delay == 0) ? 0 : int'($urandom_range(max_delay, 0));
        for (int k = 0; k <= int'(dead); k++) begin
          e.ack  = (k == 0 && !first) ? 1'b1 : (noisy ? 1'($urandom_range(1, 0)) : 1'b0);
          e.sw   = '0; e.req = 1'b0; e.busy = 1'b1; e.done = 1'b0; e.chan = 2'(c);
          trace.push_back(e);
        end
        for (int k = 0; k <= int'(settle); k++) begin
          e.ack  = noisy ? 1'($urandom_range(1, 0)) : 1'b0;
          e.sw   = 4'(1 << c); e.req = 1'b0; e.busy = 1'b1; e.done = 1'b0; e.chan = 2'(c);
          trace.push_back(e);
        end
        for (int k = 0; k <= delay; k++) begin
          e.ack  = (k == 0 && noisy) ? 1'($urandom_range(1, 0)) : 1'b0;
          e.sw   = 4'(1 << c); e.req = 1'b1; e.busy = 1'b1; e.done = 1'b0; e.chan = 2'(c);
          trace.push_back(e);
        end
        first = 1'b0;
        last_ch = 2'(c);
      end
    end
    e.ack = 1'b1; e.sw = '0; e.req = 1'b0; e.busy = 1'b0; e.done = 1'b1; e.chan = last_ch;
    trace.push_back(e);
    e.ack = noisy ? 1'($urandom_range(1, 0)) : 1'b0; e.done = 1'b0;
    trace.push_back(e);
    for (int i = 0; i < trace.size(); i++) begin
      start_i = (i == 0) ? 1'b1 :
                ((noisy && trace[i-1].busy) ? 1'($urandom_range(1, 0)) : 1'b0);
      conv_ack_i = trace[i].ack;
      continuous_i = 1'b0;
      chan_mask_i = (i == 0 || !noisy) ? mask : 4'($urandom);
      dead_cycles_i = (i == 0 || !noisy) ? dead : 8'($urandom_range(9, 0));
      settle_cycles_i = (i == 0 || !noisy) ? settle : 8'($urandom_range(9, 0));
      step();
      check_output($sformatf("%s_c%0d", tag, i), trace[i].sw, trace[i].req,
                   trace[i].busy, trace[i].done, trace[i].chan);
    end
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 8'd0, 8'd0);
  endtask

  task automatic run_sparse();
    int   visits[$];
    int   exp_order[4];
    bit   done_seen, bad_ch;
    logic prev_req;
    int   cyc;
    exp_order = '{1, 3, 1, 3};
    done_seen = 1'b0; bad_ch = 1'b0; prev_req = 1'b0; cyc = 0;
    apply_stimulus(1'b1, 1'b0, 1'b1, 1'b0, 4'b1010, 8'd1, 8'd1);
    step();
    start_i = 1'b0;
    while (!done_seen && cyc < 300) begin
      if (sw_en_o[0] || sw_en_o[2]) bad_ch = 1'b1;
      if (conv_req_o && !prev_req) begin
        visits.push_back(int'(chan_o));
        if (visits.size() == 3) continuous_i = 1'b0;
      end
      if (done_o) done_seen = 1'b1;
      prev_req = conv_req_o;
      conv_ack_i = conv_req_o;
      if (!done_seen) step();
      cyc++;
    end
    conv_ack_i = 1'b0;
    check("sparse_done_seen", 32'(done_seen), 32'd1);
    check("sparse_visit_count", 32'(visits.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      check($sformatf("sparse_order%0d", i), (i < visits.size()) ? 32'(visits[i]) : 32'hff,
            32'(exp_order[i]));
    check("sparse_ch0_ch2_never", 32'(bad_ch), 32'd0);
    step();
  endtask

  initial begin
    // start, stop, cont, ack, mask, dead, settle | sw, req, busy, done, chan
    vecs[0]  = '{1'b1,1'b0,1'b0,1'b0,4'h0,8'd0,8'd0, 4'h0,1'b0,1'b0,1'b0,2'd0};
    vecs[1]  = '{1'b1,1'b0,1'b0,1'b1,4'h1,8'd0,8'd0, 4'h0,1'b0,1'b1,1'b0,2'd0};
    vecs[2]  = '{1'b0,1'b0,1'b0,1'b1,4'h1,8'd0,8'd0, 4'h1,1'b0,1'b1,1'b0,2'd0};
    vecs[3]  = '{1'b0,1'b0,1'b0,1'b1,4'h1,8'd0,8'd0, 4'h1,1'b1,1'b1,1'b0,2'd0};
    vecs[4]  = '{1'b0,1'b0,1'b0,1'b1,4'h1,8'd0,8'd0, 4'h0,1'b0,1'b0,1'b1,2'd0};
    vecs[5]  = '{1'b0,1'b0,1'b0,1'b1,4'h1,8'd0,8'd0, 4'h0,1'b0,1'b0,1'b0,2'd0};
    vecs[6]  = '{1'b1,1'b1,1'b0,1'b0,4'h1,8'd0,8'd0, 4'h0,1'b0,1'b0,1'b0,2'd0};
    vecs[7]  = '{1'b1,1'b0,1'b0,1'b0,4'h2,8'd1,8'd0, 4'h0,1'b0,1'b1,1'b0,2'd1};
    vecs[8]  = '{1'b1,1'b0,1'b0,1'b1,4'hF,8'd5,8'd0, 4'h0,1'b0,1'b1,1'b0,2'd1};
    vecs[9]  = '{1'b0,1'b0,1'b0,1'b0,4'hF,8'd5,8'd0, 4'h2,1'b0,1'b1,1'b0,2'd1};
    vecs[10] = '{1'b0,1'b0,1'b0,1'b0,4'hF,8'd5,8'd0, 4'h2,1'b1,1'b1,1'b0,2'd1};
    vecs[11] = '{1'b0,1'b0,1'b0,1'b1,4'hF,8'd5,8'd0, 4'h0,1'b0,1'b0,1'b1,2'd1};
    vecs[12] = '{1'b0,1'b0,1'b0,1'b0,4'h0,8'd0,8'd0, 4'h0,1'b0,1'b0,1'b0,2'd1};

    step();
    step();
    check_output("reset", 4'h0, 1'b0, 1'b0, 1'b0, 2'd0);
    reset = 1'b0;

    for (int i = 0; i < 13; i++) begin
      apply_stimulus(vecs[i].start, vecs[i].stop, vecs[i].cont, vecs[i].ack,
                     vecs[i].mask, vecs[i].dead, vecs[i].settle);
      step();
      check_output($sformatf("vec%0d", i), vecs[i].sw, vecs[i].req, vecs[i].busy,
                   vecs[i].done, vecs[i].chan);
    end
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 8'd0, 8'd0);
    step();

    run_trace("basic", 4'b0011, 8'd2, 8'd3, 0, 1'b0);
    run_sparse();

    // Abort while settling.
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 4'b0001, 8'd0, 8'd5);
    step();
    start_i = 1'b0;
    step();
    step();
    check_output("stop_pre", 4'h1, 1'b0, 1'b1, 1'b0, 2'd0);
    stop_i = 1'b1;
    step();
    check_output("stop_now", 4'h0, 1'b0, 1'b0, 1'b0, 2'd0);
    stop_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check_output($sformatf("stop_after%0d", i), 4'h0, 1'b0, 1'b0, 1'b0, 2'd0);
    end

    // Converter withholds acknowledge.
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 4'b1000, 8'd1, 8'd0);
    step();
    start_i = 1'b0;
    for (int i = 0; i < 10 && !conv_req_o; i++) step();
    check("stall_req_rise", 32'(conv_req_o), 32'd1);
    for (int i = 0; i < 50; i++) begin
      step();
      check_output($sformatf("stall%0d", i), 4'h8, 1'b1, 1'b1, 1'b0, 2'd3);
    end
    conv_ack_i = 1'b1;
    step();
    check_output("stall_release", 4'h0, 1'b0, 1'b0, 1'b1, 2'd3);
    conv_ack_i = 1'b0;
    step();

    for (int r = 0; r < 20; r++)
      run_trace($sformatf("rand%0d", r), 4'($urandom_range(15, 1)),
                8'($urandom_range(4, 0)), 8'($urandom_range(4, 0)), 3, 1'b1);

    // Reset between edges while converting must open the switch immediately.
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 4'b0100, 8'd0, 8'd0);
    step();
    start_i = 1'b0;
    step();
    step();
    check_output("areset_pre", 4'h4, 1'b1, 1'b1, 1'b0, 2'd2);
    #2;
    reset = 1'b1;
    #1;
    check_output("areset_now", 4'h0, 1'b0, 1'b0, 1'b0, 2'd0);
    #3;
    reset = 1'b0;
    step();
    check_output("areset_after", 4'h0, 1'b0, 1'b0, 1'b0, 2'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
